sd_bus_sched: RTL and testbench

Scheduler and bus owner for the shared SD SPI lines. Arbitrates user read and write sector requests, with round-robin between them. Launches the read/write engines with start pulses and sector addresses, waits for each engine's busy handshake, and multiplexes the engine that owns the bus onto sd_cs/sd_mosi. Sits between the user logic and the init/read/write engines, all on clk_ref.

---
 rtl/sd_bus_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_sd_bus_sched.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_bus_sched.sv
// Scheduler and SPI bus owner for the shared SD lines: round-robin arbitration of read/write
// sector requests, engine launch and busy handshake. Optional busy watchdog: SD_SCHED_WATCHDOG_EN.
module sd_bus_sched #(
  parameter int unsigned BUSY_HI_WAIT = 16,
  parameter logic [31:0] BUSY_TIMEOUT = 32'd50_000_000
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        wr_cs,
  input  logic        wr_mosi,
  input  logic        wr_busy,
  input  logic        rd_cs,
  input  logic        rd_mosi,
  input  logic        rd_busy,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        wr_start_en,
  output logic        rd_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [31:0] rd_sec_addr,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [31:0] wr_req_addr,
  input  logic [31:0] rd_req_addr,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        wr_done,
  output logic        rd_done,
  output logic        sched_err,
  output logic [2:0]  dbg_state
);

  // Handshake: a user holds *_req (with *_req_addr valid) until the one-cycle *_ack pulse;
  // the address is captured on that same edge. Engines see a start level that stays high
  // until their busy rises, and *_done pulses once after the granted busy falls.

  localparam int HI_W = $clog2(BUSY_HI_WAIT + 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_INIT = 2'd0,
    OWN_NONE = 2'd1,
    OWN_WR   = 2'd2,
    OWN_RD   = 2'd3
  } owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic              grant_wr, grant_wr_nxt;
  logic              last_wr, last_wr_nxt;
  logic [HI_W-1:0]   hi_cnt, hi_cnt_nxt;
  logic              gap_cnt, gap_cnt_nxt;
  logic              wr_start_nxt, rd_start_nxt;
  logic [31:0]       wr_addr_nxt, rd_addr_nxt;
  logic              wr_ack_nxt, rd_ack_nxt;
  logic              wr_done_nxt, rd_done_nxt;
  logic              err_nxt;
  logic              pick_wr;
  logic              grant_busy;
`ifdef SD_SCHED_WATCHDOG_EN
  logic [31:0]       wd_cnt, wd_cnt_nxt;
`endif

  // Only the granted engine's busy matters; the other is ignored entirely.
  assign grant_busy = grant_wr ? wr_busy : rd_busy;
  assign dbg_state  = state;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    grant_wr_nxt = grant_wr;
    last_wr_nxt  = last_wr;
    hi_cnt_nxt   = hi_cnt;
    gap_cnt_nxt  = gap_cnt;
    wr_start_nxt = wr_start_en;
    rd_start_nxt = rd_start_en;
    wr_addr_nxt  = wr_sec_addr;
    rd_addr_nxt  = rd_sec_addr;
    wr_ack_nxt   = 1'b0;
    rd_ack_nxt   = 1'b0;
    wr_done_nxt  = 1'b0;
    rd_done_nxt  = 1'b0;
    err_nxt      = 1'b0;
    pick_wr      = 1'b0;
`ifdef SD_SCHED_WATCHDOG_EN
    wd_cnt_nxt   = wd_cnt;
`endif

    case (state)
      S_INIT: begin
        if (sd_init_done) begin
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
        end
      end

      S_IDLE: begin
        if (wr_req || rd_req) begin
          // On contention the side that did not complete last wins.
          pick_wr      = (wr_req && rd_req) ? !last_wr : wr_req;
          grant_wr_nxt = pick_wr;
          hi_cnt_nxt   = HI_W'(1);
          state_nxt    = S_WAIT_HI;
          if (pick_wr) begin
            wr_ack_nxt   = 1'b1;
            wr_addr_nxt  = wr_req_addr;
            wr_start_nxt = 1'b1;
            owner_nxt    = OWN_WR;
          end else begin
            rd_ack_nxt   = 1'b1;
            rd_addr_nxt  = rd_req_addr;
            rd_start_nxt = 1'b1;
            owner_nxt    = OWN_RD;
          end
        end
      end

      S_WAIT_HI: begin
        if (grant_busy) begin
          wr_start_nxt = 1'b0;
          rd_start_nxt = 1'b0;
          state_nxt    = S_WAIT_LO;
`ifdef SD_SCHED_WATCHDOG_EN
          wd_cnt_nxt   = 32'd1;
`endif
        end else if (hi_cnt == HI_W'(BUSY_HI_WAIT)) begin
          wr_start_nxt = 1'b0;
          rd_start_nxt = 1'b0;
          err_nxt      = 1'b1;
          owner_nxt    = OWN_NONE;
          state_nxt    = S_IDLE;
        end else begin
          hi_cnt_nxt = HI_W'(hi_cnt + 1'b1);
        end
      end

      S_WAIT_LO: begin
        if (!grant_busy) begin
          wr_done_nxt = grant_wr;
          rd_done_nxt = !grant_wr;
          last_wr_nxt = grant_wr;
          owner_nxt   = OWN_NONE;
          gap_cnt_nxt = 1'b0;
          state_nxt   = S_GAP;
        end
`ifdef SD_SCHED_WATCHDOG_EN
        else if (wd_cnt == BUSY_TIMEOUT) begin
          err_nxt     = 1'b1;
          owner_nxt   = OWN_NONE;
          gap_cnt_nxt = 1'b0;
          state_nxt   = S_GAP;
        end else begin
          wd_cnt_nxt = wd_cnt + 32'd1;
        end
`endif
      end

      // Two idle cycles so the next start_en is a clean rising edge for the engines.
      S_GAP: begin
        owner_nxt = OWN_NONE;
        if (gap_cnt) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_INIT;
        owner_nxt = OWN_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      owner       <= OWN_INIT;
      grant_wr    <= 1'b0;
      last_wr     <= 1'b0;
      hi_cnt      <= '0;
      gap_cnt     <= 1'b0;
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      wr_sec_addr <= 32'd0;
      rd_sec_addr <= 32'd0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      sched_err   <= 1'b0;
`ifdef SD_SCHED_WATCHDOG_EN
      wd_cnt      <= 32'd0;
`endif
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      grant_wr    <= grant_wr_nxt;
      last_wr     <= last_wr_nxt;
      hi_cnt      <= hi_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      wr_start_en <= wr_start_nxt;
      rd_start_en <= rd_start_nxt;
      wr_sec_addr <= wr_addr_nxt;
      rd_sec_addr <= rd_addr_nxt;
      wr_ack      <= wr_ack_nxt;
      rd_ack      <= rd_ack_nxt;
      wr_done     <= wr_done_nxt;
      rd_done     <= rd_done_nxt;
      sched_err   <= err_nxt;
`ifdef SD_SCHED_WATCHDOG_EN
      wd_cnt      <= wd_cnt_nxt;
`endif
    end
  end

  // Bus mux; idle lines are held high so the card sees a deselected, quiet bus.
  always_comb begin
    sd_cs   = 1'b1;
    sd_mosi = 1'b1;
    case (owner)
      OWN_INIT: begin
        sd_cs   = init_cs;
        sd_mosi = init_mosi;
      end
      OWN_WR: begin
        sd_cs   = wr_cs;
        sd_mosi = wr_mosi;
      end
      OWN_RD: begin
        sd_cs   = rd_cs;
        sd_mosi = rd_mosi;
      end
      default: begin
        sd_cs   = 1'b1;
        sd_mosi = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_bus_sched.sv
// Bench for sd_bus_sched: grants are predicted into exp_q as requests are driven and
// popped at each ack; completions go through done_q.
module tb_sd_bus_sched;

`ifdef SD_SCHED_WATCHDOG_EN
  localparam int READ_BUSY_LEN = 50;
`else
  localparam int READ_BUSY_LEN = 1000;
`endif

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        sd_init_done;
  logic        init_cs, init_mosi;
  logic        wr_cs, wr_mosi, wr_busy;
  logic        rd_cs, rd_mosi, rd_busy;
  logic        sd_cs, sd_mosi;
  logic        wr_start_en, rd_start_en;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic        wr_req, rd_req;
  logic [31:0] wr_req_addr, rd_req_addr;
  logic        wr_ack, rd_ack, wr_done, rd_done, sched_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [0:0]  done_q[$];
  logic        model_last_wr;
  logic        cur_wr;
  logic [31:0] cur_addr;

  always #5 clk_ref = ~clk_ref;

  sd_bus_sched #(.BUSY_HI_WAIT(16), .BUSY_TIMEOUT(32'd100)) dut (
    .clk_ref(clk_ref), .rst(rst), .sd_init_done(sd_init_done),
    .init_cs(init_cs), .init_mosi(init_mosi),
    .wr_cs(wr_cs), .wr_mosi(wr_mosi), .wr_busy(wr_busy),
    .rd_cs(rd_cs), .rd_mosi(rd_mosi), .rd_busy(rd_busy),
    .sd_cs(sd_cs), .sd_mosi(sd_mosi),
    .wr_start_en(wr_start_en), .rd_start_en(rd_start_en),
    .wr_sec_addr(wr_sec_addr), .rd_sec_addr(rd_sec_addr),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_req_addr(wr_req_addr), .rd_req_addr(rd_req_addr),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_done(wr_done), .rd_done(rd_done),
    .sched_err(sched_err), .dbg_state(dbg_state)
  );

  task automatic drive_engines();
    wr_cs   = 1'($urandom_range(0, 1));
    wr_mosi = 1'($urandom_range(0, 1));
    rd_cs   = 1'($urandom_range(0, 1));
    rd_mosi = 1'($urandom_range(0, 1));
  endtask

  task automatic await_ack(input int exp_lat);
    logic [32:0] exp;
    int n;
    n = 0;
    while (!(wr_ack || rd_ack) && n < 40) begin
      @(negedge clk_ref);
      n++;
    end
    exp = 33'h0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    cur_wr = exp[32];
    cur_addr = exp[31:0];
    checks++;
    if ({wr_ack, rd_ack} !== {exp[32], ~exp[32]}) begin
      failures++;
      $display("FAIL ack_sel got wr_ack/rd_ack=%b%b exp=%b%b", wr_ack, rd_ack, exp[32], ~exp[32]);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (n !== exp_lat) begin
        failures++;
        $display("FAIL ack_latency got=%0d exp=%0d", n, exp_lat);
      end
    end
    checks++;
    if ((exp[32] ? wr_sec_addr : rd_sec_addr) !== exp[31:0]) begin
      failures++;
      $display("FAIL sec_addr got=%h exp=%h", exp[32] ? wr_sec_addr : rd_sec_addr, exp[31:0]);
    end
    checks++;
    if ({wr_start_en, rd_start_en} !== {exp[32], ~exp[32]}) begin
      failures++;
      $display("FAIL start_rise got=%b%b exp=%b%b", wr_start_en, rd_start_en, exp[32], ~exp[32]);
    end
    if (exp[32]) begin
      wr_req = 1'b0;
      wr_req_addr = ~exp[31:0];
    end else begin
      rd_req = 1'b0;
      rd_req_addr = ~exp[31:0];
    end
  endtask

  task automatic issue(input bit is_wr, input logic [31:0] addr, input int exp_lat);
    if (is_wr) begin
      wr_req_addr = addr;
      wr_req = 1'b1;
    end else begin
      rd_req_addr = addr;
      rd_req = 1'b1;
    end
    exp_q.push_back({is_wr, addr});
    await_ack(exp_lat);
  endtask

  // Emulates the granted engine: busy two cycles after start, held busy_len cycles.
  task automatic serve(input int busy_len);
    logic [1:0] exp_mux;
    logic [0:0] exp_d;
    int n;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ref);
      drive_engines();
      #1;
      exp_mux = cur_wr ? {wr_cs, wr_mosi} : {rd_cs, rd_mosi};
      checks++;
      if ({sd_cs, sd_mosi} !== exp_mux) begin
        failures++;
        $display("FAIL mux_wait_hi got=%b exp=%b", {sd_cs, sd_mosi}, exp_mux);
      end
      checks++;
      if ((cur_wr ? wr_start_en : rd_start_en) !== 1'b1) begin
        failures++;
        $display("FAIL start_hold got=0 exp=1");
      end
    end
    if (cur_wr) wr_busy = 1'b1; else rd_busy = 1'b1;
    @(negedge clk_ref);
    checks++;
    if ({wr_start_en, rd_start_en, dbg_state} !== {2'b00, 3'd3}) begin
      failures++;
      $display("FAIL start_drop got start=%b%b state=%0d exp start=00 state=3",
               wr_start_en, rd_start_en, dbg_state);
    end
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk_ref);
      drive_engines();
      #1;
      exp_mux = cur_wr ? {wr_cs, wr_mosi} : {rd_cs, rd_mosi};
      checks++;
      if ({sd_cs, sd_mosi, wr_done, rd_done} !== {exp_mux, 2'b00}) begin
        failures++;
        $display("FAIL mux_busy cycle=%0d got=%b%b done=%b%b exp=%b done=00",
                 i, sd_cs, sd_mosi, wr_done, rd_done, exp_mux);
      end
    end
    @(negedge clk_ref);
    if (cur_wr) begin
      wr_busy = 1'b0; wr_cs = 1'b0; wr_mosi = 1'b0;
    end else begin
      rd_busy = 1'b0; rd_cs = 1'b0; rd_mosi = 1'b0;
    end
    done_q.push_back(cur_wr);
    n = 0;
    while (!(wr_done || rd_done) && n < 8) begin
      @(negedge clk_ref);
      n++;
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=1", n);
    end
    exp_d = done_q.pop_front();
    checks++;
    if ({wr_done, rd_done} !== {exp_d[0], ~exp_d[0]}) begin
      failures++;
      $display("FAIL done_sel got=%b%b exp=%b%b", wr_done, rd_done, exp_d[0], ~exp_d[0]);
    end
    checks++;
    if ({sd_cs, sd_mosi} !== 2'b11) begin
      failures++;
      $display("FAIL mux_none got=%b%b exp=11", sd_cs, sd_mosi);
    end
    checks++;
    if ((cur_wr ? wr_sec_addr : rd_sec_addr) !== cur_addr) begin
      failures++;
      $display("FAIL sec_addr_hold got=%h exp=%h", cur_wr ? wr_sec_addr : rd_sec_addr, cur_addr);
    end
    model_last_wr = cur_wr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sd_init_done = 1'b0;
    init_cs = 1'b0; init_mosi = 1'b1;
    wr_cs = 1'b1; wr_mosi = 1'b1; wr_busy = 1'b0;
    rd_cs = 1'b1; rd_mosi = 1'b1; rd_busy = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_req_addr = 32'd0; rd_req_addr = 32'd0;
    repeat (3) @(negedge clk_ref);
    checks++;
    if ({sd_cs, sd_mosi} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mux got=%b%b exp=01", sd_cs, sd_mosi);
    end
    checks++;
    if ({wr_start_en, rd_start_en, wr_ack, rd_ack, wr_done, rd_done, sched_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000000",
               {wr_start_en, rd_start_en, wr_ack, rd_ack, wr_done, rd_done, sched_err});
    end
    checks++;
    if ({wr_sec_addr, rd_sec_addr} !== 64'd0) begin
      failures++;
      $display("FAIL reset_addr got=%h/%h exp=0/0", wr_sec_addr, rd_sec_addr);
    end
    rst = 1'b0;
    model_last_wr = 1'b0;
  endtask

  task automatic test_init();
    @(negedge clk_ref);
    init_cs = 1'b0; init_mosi = 1'b0;
    #1;
    checks++;
    if ({sd_cs, sd_mosi, dbg_state} !== {2'b00, 3'd0}) begin
      failures++;
      $display("FAIL init_mux got=%b%b state=%0d exp=00 state=0", sd_cs, sd_mosi, dbg_state);
    end
    @(negedge clk_ref);
    sd_init_done = 1'b1;
    @(negedge clk_ref);
    checks++;
    if ({sd_cs, sd_mosi, dbg_state} !== {2'b11, 3'd1}) begin
      failures++;
      $display("FAIL init_done got=%b%b state=%0d exp=11 state=1", sd_cs, sd_mosi, dbg_state);
    end
    sd_init_done = 1'b0;
  endtask

  task automatic test_read();
    issue(1'b0, 32'h0000_1234, 1);
    serve(READ_BUSY_LEN);
  endtask

  task automatic test_arbitration();
    bit g;
    logic [31:0] a;
    wr_req_addr = $urandom();
    rd_req_addr = $urandom();
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      g = ~model_last_wr;
      exp_q.push_back({g, g ? wr_req_addr : rd_req_addr});
      await_ack(k == 0 ? -1 : 3);
      serve($urandom_range(3, 20));
      a = $urandom();
      if (cur_wr) begin
        wr_req_addr = a; wr_req = 1'b1;
      end else begin
        rd_req_addr = a; rd_req = 1'b1;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_hi_timeout();
    int n;
    repeat (4) @(negedge clk_ref);
    rd_cs = 1'b0; rd_mosi = 1'b0;
    issue(1'b0, 32'hDEAD_0001, 1);
    n = 0;
    while (!sched_err && n < 40) begin
      @(negedge clk_ref);
      n++;
      checks++;
      if (rd_done !== 1'b0) begin
        failures++;
        $display("FAIL hi_no_done got=1 exp=0");
      end
      if (!sched_err) begin
        checks++;
        if (rd_start_en !== 1'b1) begin
          failures++;
          $display("FAIL hi_start_hold cycle=%0d got=0 exp=1", n);
        end
      end
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL hi_timeout_cycles got=%0d exp=16", n);
    end
    checks++;
    if ({rd_start_en, sd_cs, sd_mosi} !== 3'b011) begin
      failures++;
      $display("FAIL hi_timeout_outs got start=%b sd=%b%b exp start=0 sd=11", rd_start_en, sd_cs, sd_mosi);
    end
    @(negedge clk_ref);
    checks++;
    if ({sched_err, rd_done} !== 2'b00) begin
      failures++;
      $display("FAIL hi_err_pulse got=%b%b exp=00", sched_err, rd_done);
    end
    issue(1'b1, 32'h0000_5678, 1);
    serve(10);
  endtask

`ifdef SD_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    repeat (3) @(negedge clk_ref);
    issue(1'b1, 32'h0000_0BAD, 1);
    @(negedge clk_ref);
    @(negedge clk_ref);
    wr_busy = 1'b1; wr_cs = 1'b0; wr_mosi = 1'b0;
    n = 0;
    while (!sched_err && n < 300) begin
      @(negedge clk_ref);
      n++;
      checks++;
      if (wr_done !== 1'b0) begin
        failures++;
        $display("FAIL wd_no_done got=1 exp=0");
      end
    end
    checks++;
    if (n !== 101) begin
      failures++;
      $display("FAIL wd_cycles got=%0d exp=101", n);
    end
    checks++;
    if ({sd_cs, sd_mosi} !== 2'b11) begin
      failures++;
      $display("FAIL wd_mux got=%b%b exp=11", sd_cs, sd_mosi);
    end
    wr_busy = 1'b0;
    repeat (4) begin
      @(negedge clk_ref);
      checks++;
      if (wr_done !== 1'b0) begin
        failures++;
        $display("FAIL wd_late_done got=1 exp=0");
      end
    end
  endtask
`endif

  task automatic test_reset_midop();
    repeat (4) @(negedge clk_ref);
    issue(1'b0, 32'hCAFE_0042, 1);
    @(negedge clk_ref);
    @(negedge clk_ref);
    rd_busy = 1'b1;
    repeat (5) @(negedge clk_ref);
    checks++;
    if (dbg_state !== 3'd3) begin
      failures++;
      $display("FAIL midop_state got=%0d exp=3", dbg_state);
    end
    init_cs = 1'b0; init_mosi = 1'b1;
    rd_cs = 1'b1; rd_mosi = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sd_cs, sd_mosi, rd_start_en, rd_done, dbg_state} !== {2'b01, 2'b00, 3'd0}) begin
      failures++;
      $display("FAIL async_reset got sd=%b%b start=%b done=%b state=%0d exp sd=01 start=0 done=0 state=0",
               sd_cs, sd_mosi, rd_start_en, rd_done, dbg_state);
    end
    checks++;
    if (rd_sec_addr !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_addr got=%h exp=0", rd_sec_addr);
    end
    rd_busy = 1'b0;
    sd_init_done = 1'b0;
    model_last_wr = 1'b0;
    @(negedge clk_ref);
    rst = 1'b0;
    wr_req_addr = 32'h0BAD_F00D;
    wr_req = 1'b1;
    exp_q.push_back({1'b1, 32'h0BAD_F00D});
    repeat (4) begin
      @(negedge clk_ref);
      checks++;
      if (wr_ack !== 1'b0) begin
        failures++;
        $display("FAIL pending_ack got=1 exp=0");
      end
    end
    sd_init_done = 1'b1;
    await_ack(2);
    serve(20);
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_arbitration();
    test_hi_timeout();
`ifdef SD_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_midop();
    repeat (4) @(negedge clk_ref);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

endmodule
